// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - pipelined barrel shifter/rotator with valid/ready handshake
//
// Purpose: WIDTH-bit rotate / logical shift / arithmetic shift / pass-through,
// split into SHW register stages. Stage k moves the data by 2^k when amt bit k
// is set. The operand's direction, mode, amount and original MSB travel down
// the pipe with it. The whole pipe freezes while the output beat is refused.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (beat taken when both are high)
//   in_data [WIDTH]       operand
//   in_amt  [SHW]         shift/rotate amount
//   in_dir                0 = left, 1 = right
//   in_mode [2]           00 rotate, 01 logical, 10 arithmetic, 11 pass-through
//   out_valid / out_ready output handshake (beat consumed when both are high)
//   out_data [WIDTH]      result, driven straight from the last stage register
module barrel_shifter_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic             in_dir,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam logic [1:0] MODE_ROT  = 2'b00;
   localparam logic [1:0] MODE_LSH  = 2'b01;
   localparam logic [1:0] MODE_ASH  = 2'b10;

   logic             stall;

   // Stage registers
   logic [SHW-1:0]   vld_q;
   logic [WIDTH-1:0] data_q [SHW];
   logic [SHW-1:0]   amt_q  [SHW];
   logic             dir_q  [SHW];
   logic [1:0]       mode_q [SHW];
   logic             sign_q [SHW];

   // Values presented to each stage (input port for stage 0, previous stage otherwise)
   logic [SHW-1:0]   vld_d;
   logic [WIDTH-1:0] data_d [SHW];
   logic [SHW-1:0]   amt_d  [SHW];
   logic             dir_d  [SHW];
   logic [1:0]       mode_d [SHW];
   logic             sign_d [SHW];

   // One stage of the shifter: move d by 2^k when en is set.
   // The arithmetic fill uses the sign captured at the input, not d's current MSB.
   function automatic logic [WIDTH-1:0] stage_op(
      input logic [WIDTH-1:0] d,
      input int               k,
      input logic             en,
      input logic             dir,
      input logic [1:0]       mode,
      input logic             sign
   );
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] fill;
      int               s;
      s    = 1 << k;
      fill = sign ? ~({WIDTH{1'b1}} >> s) : '0;
      r    = d;
      if (en) begin
         case (mode)
            MODE_ROT: r = dir ? ((d >> s) | (d << (WIDTH - s)))
                              : ((d << s) | (d >> (WIDTH - s)));
            MODE_LSH: r = dir ? (d >> s) : (d << s);
            MODE_ASH: r = dir ? ((d >> s) | fill) : (d << s);
            default:  r = d;
         endcase
      end
      return r;
   endfunction

   assign stall     = vld_q[SHW-1] && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = vld_q[SHW-1];
   assign out_data  = data_q[SHW-1];

   always_comb begin
      vld_d[0]  = in_valid;
      data_d[0] = in_data;
      amt_d[0]  = in_amt;
      dir_d[0]  = in_dir;
      mode_d[0] = in_mode;
      sign_d[0] = in_data[WIDTH-1];
      for (int k = 1; k < SHW; k++) begin
         vld_d[k]  = vld_q[k-1];
         data_d[k] = data_q[k-1];
         amt_d[k]  = amt_q[k-1];
         dir_d[k]  = dir_q[k-1];
         mode_d[k] = mode_q[k-1];
         sign_d[k] = sign_q[k-1];
      end
   end

   // Valid flags advance every unstalled cycle (bubbles included); payload
   // registers load only with a valid beat so idle inputs never enter the pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < SHW; k++) begin
            data_q[k] <= '0;
            amt_q[k]  <= '0;
            dir_q[k]  <= 1'b0;
            mode_q[k] <= 2'b00;
            sign_q[k] <= 1'b0;
         end
      end else if (!stall) begin
         vld_q <= vld_d;
         for (int k = 0; k < SHW; k++) begin
            if (vld_d[k]) begin
               data_q[k] <= stage_op(data_d[k], k, amt_d[k][k], dir_d[k], mode_d[k], sign_d[k]);
               amt_q[k]  <= amt_d[k];
               dir_q[k]  <= dir_d[k];
               mode_q[k] <= mode_d[k];
               sign_q[k] <= sign_d[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb/tb_barrel_shifter_pipe.sv - self-checking bench for barrel_shifter_pipe (WIDTH 8 and 4)
module tb_barrel_shifter_pipe;

   localparam int SHW8 = 3;

   typedef struct {
      logic [7:0] d;
      logic [2:0] a;
      logic       dir;
      logic [1:0] m;
      logic [7:0] e;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      int         c;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_data, out_data;
   logic [2:0] in_amt;
   logic       in_dir;
   logic [1:0] in_mode;

   logic       in_valid4, in_ready4, out_valid4, out_ready4;
   logic [3:0] in_data4, out_data4;
   logic [1:0] in_amt4;
   logic       in_dir4;
   logic [1:0] in_mode4;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         n_out = 0;
   exp_t       exp_q[$];
   exp_t       mon_e;
   bit         use_exp = 0;
   logic [7:0] cur_exp = '0;
   bit         chk_lat = 1;
   bit         prev_stall = 0;
   logic [7:0] prev_data = '0;

   barrel_shifter_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_amt(in_amt), .in_dir(in_dir), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   barrel_shifter_pipe #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
      .in_amt(in_amt4), .in_dir(in_dir4), .in_mode(in_mode4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Bit-level statement of the operation: each result bit picks its source bit.
   function automatic logic [7:0] ref_model(input logic [7:0] d, input int a,
                                            input logic dir, input logic [1:0] m);
      logic [7:0] r;
      int         src;
      r = '0;
      if (m == 2'b11) return d;
      for (int i = 0; i < 8; i++) begin
         src = dir ? i + a : i - a;
         if (m == 2'b00)                r[i] = d[(src + 8) % 8];
         else if (src >= 0 && src < 8)  r[i] = d[src];
         else if (m == 2'b10 && dir)    r[i] = d[7];
         else                           r[i] = 1'b0;
      end
      return r;
   endfunction

   // The old 4-bit rotator: slice a doubled operand.
   function automatic logic [3:0] legacy_rot(input logic [3:0] d, input int a, input logic dir);
      logic [7:0] dd;
      dd = {d, d};
      if (dir) begin
         dd = dd >> a;
         return dd[3:0];
      end
      dd = dd << a;
      return dd[7:4];
   endfunction

   // Scoreboard / protocol monitor for the 8-bit instance
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_data", 32'(out_data), 32'(prev_data));
         end
         chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (exp_q.size() == 0) begin
            chk("no_stale_output", 32'(out_valid), 32'(0));
         end else if (out_valid && out_ready) begin
            n_out++;
            mon_e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(mon_e.d));
            if (chk_lat) chk("latency", 32'(cyc - mon_e.c), 32'(SHW8));
         end
         if (in_valid && in_ready) begin
            mon_e.d = use_exp ? cur_exp : ref_model(in_data, int'(in_amt), in_dir, in_mode);
            mon_e.c = cyc;
            exp_q.push_back(mon_e);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end else begin
         prev_stall = 0;
      end
   end

   // Present one beat and hold it until accepted; returns at posedge+1.
   task automatic send(input logic [7:0] d, input logic [2:0] a, input logic dir,
                       input logic [1:0] m, output int waited);
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_dir   = dir;
      in_mode  = m;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", 32'(in_ready), 32'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'(0));
   endtask

   vec_t       vecs [17];
   logic [3:0] leg_exp [128];

   initial begin
      int w;
      int n0;

      vecs[0]  = '{8'hB1, 3'd3, 1'b0, 2'b00, 8'h8D};
      vecs[1]  = '{8'hB1, 3'd1, 1'b1, 2'b00, 8'hD8};
      vecs[2]  = '{8'h90, 3'd2, 1'b1, 2'b01, 8'h24};
      vecs[3]  = '{8'h90, 3'd2, 1'b1, 2'b10, 8'hE4};
      vecs[4]  = '{8'h90, 3'd1, 1'b0, 2'b10, 8'h20};
      vecs[5]  = '{8'h5A, 3'd5, 1'b1, 2'b11, 8'h5A};
      vecs[6]  = '{8'hC3, 3'd0, 1'b0, 2'b00, 8'hC3};
      vecs[7]  = '{8'hC3, 3'd0, 1'b1, 2'b01, 8'hC3};
      vecs[8]  = '{8'hC3, 3'd0, 1'b1, 2'b10, 8'hC3};
      vecs[9]  = '{8'h80, 3'd7, 1'b1, 2'b01, 8'h01};
      vecs[10] = '{8'hFF, 3'd7, 1'b1, 2'b01, 8'h01};
      vecs[11] = '{8'h80, 3'd7, 1'b1, 2'b10, 8'hFF};
      vecs[12] = '{8'h81, 3'd7, 1'b1, 2'b10, 8'hFF};
      vecs[13] = '{8'h70, 3'd4, 1'b1, 2'b10, 8'h07};
      vecs[14] = '{8'hFF, 3'd7, 1'b0, 2'b01, 8'h80};
      vecs[15] = '{8'h01, 3'd7, 1'b1, 2'b00, 8'h02};
      vecs[16] = '{8'h3C, 3'd0, 1'b0, 2'b11, 8'h3C};

      rst_n = 1'b0;
      in_valid = 0; in_data = '0; in_amt = '0; in_dir = 0; in_mode = '0; out_ready = 1;
      in_valid4 = 0; in_data4 = '0; in_amt4 = '0; in_dir4 = 0; in_mode4 = 2'b00; out_ready4 = 1;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'(0));
      chk("reset_out_data", 32'(out_data), 32'(0));
      chk("reset_in_ready", 32'(in_ready), 32'(1));
      chk("reset_out_valid4", 32'(out_valid4), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors, one at a time
      use_exp = 1;
      foreach (vecs[i]) begin
         cur_exp = vecs[i].e;
         send(vecs[i].d, vecs[i].a, vecs[i].dir, vecs[i].m, w);
         drain();
      end
      use_exp = 0;

      // Full rate: 16 random beats back-to-back
      for (int i = 0; i < 16; i++) begin
         send(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom_range(0, 3)), w);
         chk("full_rate_no_wait", 32'(w), 32'(0));
      end
      drain();

      // Backpressure: 8 beats, out_ready low for 4 cycles with the pipe full
      chk_lat = 0;
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom_range(0, 3)), w);
         end
         begin
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               chk("bp_in_ready_low", 32'(in_ready), 32'(0));
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_beats_out", 32'(n_out - n0), 32'(8));
      chk_lat = 1;

      // Reset with 3 beats in flight
      for (int i = 0; i < 3; i++)
         send(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom_range(0, 3)), w);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid_now", 32'(out_valid), 32'(0));
      chk("rst_out_data_now", 32'(out_data), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_no_stale", 32'(out_valid), 32'(0));
      end
      @(posedge clk);
      #1;
      send(8'hA5, 3'd2, 1'b1, 2'b10, w);
      drain();

      // Legacy equivalence on the 4-bit instance: 128 combos streamed back-to-back
      for (int i = 0; i < 128; i++)
         leg_exp[i] = legacy_rot(4'(i), (i >> 4) & 3, 1'((i >> 6) & 1));
      for (int i = 0; i < 130; i++) begin
         @(posedge clk);
         #1;
         if (i < 128) begin
            in_valid4 = 1'b1;
            in_data4  = 4'(i);
            in_amt4   = 2'((i >> 4) & 3);
            in_dir4   = 1'((i >> 6) & 1);
         end else begin
            in_valid4 = 1'b0;
         end
         @(negedge clk);
         if (i < 2) begin
            chk("legacy_fill", 32'(out_valid4), 32'(0));
         end else begin
            chk("legacy_valid", 32'(out_valid4), 32'(1));
            chk("legacy_data", 32'(out_data4), 32'(leg_exp[i-2]));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
